// File: rtl/mxu_pkg.sv
// rtl/mxu_pkg.sv - shared types for the MXU result drain (FSM state, result element/matrix)
package mxu_pkg;

  localparam int MXU_DIM           = 4;
  localparam int MXU_OUT_BIT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

  typedef logic [MXU_OUT_BIT_WIDTH-1:0]              mxu_elem_t;
  typedef mxu_elem_t [MXU_DIM-1:0][MXU_DIM-1:0]      mxu_matrix_t;

endpackage

// File: rtl/Counter.sv
// rtl/Counter.sv - wrapping up-counter with synchronous clear and count enable
module Counter #(
  parameter int WIDTH = 2,
  parameter int MAX   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count 0..MAX and wrap; clear has priority over enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == WIDTH'(MAX)) ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mxu_requant.sv
// rtl/mxu_requant.sv - narrows one result element; MXU_DRAIN_SAT_EN selects clamping over truncation
module mxu_requant
  import mxu_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 6
) (
  input  logic [IN_W-1:0]  value,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

`ifdef MXU_DRAIN_SAT_EN
  // Any set bit above the output range means the value exceeds the output max.
  generate
    if (OUT_W < IN_W) begin : g_clamp
      assign sat  = |value[IN_W-1:OUT_W];
      assign data = sat ? {OUT_W{1'b1}} : value[OUT_W-1:0];
    end else begin : g_pass
      assign sat  = 1'b0;
      assign data = value[OUT_W-1:0];
    end
  endgenerate
`else
  assign data = value[OUT_W-1:0];
  assign sat  = 1'b0;
`endif

endmodule

// File: rtl/mxu_result_drain.sv
// rtl/mxu_result_drain.sv - captures the MXU result matrix and streams it row-major (option: MXU_DRAIN_SAT_EN)
module mxu_result_drain
  import mxu_pkg::*;
#(
  parameter int DIM            = 4,
  parameter int DIM_BITS       = $clog2(DIM),
  parameter int OUT_BIT_WIDTH  = 8,
  parameter int DATA_OUT_WIDTH = 6
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [DIM-1:0][DIM-1:0][OUT_BIT_WIDTH-1:0]   mxu_out,
  input  logic                                         mxu_out_valid,
  output logic [DATA_OUT_WIDTH-1:0]                    d_data,
  output logic [DIM_BITS-1:0]                          d_row,
  output logic [DIM_BITS-1:0]                          d_col,
  output logic                                         d_valid,
  input  logic                                         d_ready,
  output logic                                         d_last,
  output logic                                         d_sat,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         overrun
);

  drain_state_t state, state_next;

  logic [DIM-1:0][DIM-1:0][OUT_BIT_WIDTH-1:0] buffer;
  logic prev;
  logic cap;
  logic handshake;
  logic last_col;
  logic final_hs;
  logic load;

  assign cap       = mxu_out_valid & ~prev;
  assign handshake = d_valid & d_ready;
  assign last_col  = (d_col == DIM_BITS'(DIM - 1));
  assign d_last    = last_col & (d_row == DIM_BITS'(DIM - 1));
  assign final_hs  = handshake & d_last;
  // A capture is accepted when idle, or when it lands exactly on the final handshake.
  assign load      = cap & ((state == IDLE) | final_hs);

  // Edge-detect history, end-of-drain pulse and sticky dropped-capture flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      prev <= mxu_out_valid;
      done <= final_hs;
      if (cap & (state == SEND) & ~final_hs) begin
        overrun <= 1'b1;
      end
    end
  end

  // Result buffer; only written by an accepted capture so draining is never disturbed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buffer <= '0;
    end else if (load) begin
      buffer <= mxu_out;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and stream-side status outputs.
  always_comb begin
    state_next = state;
    d_valid    = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (cap) begin
          state_next = SEND;
        end
      end
      SEND: begin
        d_valid = 1'b1;
        busy    = 1'b1;
        if (final_hs && !cap) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  Counter #(
    .WIDTH (DIM_BITS),
    .MAX   (DIM - 1)
  ) u_col_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (load),
    .en      (handshake),
    .count   (d_col)
  );

  Counter #(
    .WIDTH (DIM_BITS),
    .MAX   (DIM - 1)
  ) u_row_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (load),
    .en      (handshake & last_col),
    .count   (d_row)
  );

  mxu_requant #(
    .IN_W  (OUT_BIT_WIDTH),
    .OUT_W (DATA_OUT_WIDTH)
  ) u_requant (
    .value (buffer[d_row][d_col]),
    .data  (d_data),
    .sat   (d_sat)
  );

endmodule

// File: doc/mxu_result_drain.md
# mxu_result_drain

Downstream stage of the temporal MXU. It captures the full DIM×DIM result matrix when the MXU's `out_valid` rises. It then streams the elements one per handshake, in row-major order, over a valid/ready interface. Each element is requantized to a narrower output width on the way out. This frees the MXU result registers for the next job and presents results to the write-back path serially.

## Interface
Parameters:
- `DIM`, 4: matrix dimension.
- `DIM_BITS`, `$clog2(DIM)`: row/column index width.
- `OUT_BIT_WIDTH`, 8: width of each incoming MXU result element (unsigned).
- `DATA_OUT_WIDTH`, 6: width of each streamed element. Must satisfy `DATA_OUT_WIDTH <= OUT_BIT_WIDTH`.

Ports:
- `clk`  in  1: single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `mxu_out`  in  `[DIM-1:0][DIM-1:0][OUT_BIT_WIDTH-1:0]`: result matrix from the MXU.
- `mxu_out_valid`  in  1: level signal; a rising edge means a new matrix is ready.
- `d_data`  out  `DATA_OUT_WIDTH`: current element.
- `d_row`, `d_col`  out  `DIM_BITS`: index of the current element.
- `d_valid`  out  1: element valid.
- `d_ready`  in  1: consumer accepts the element.
- `d_last`  out  1: current element is (DIM-1, DIM-1).
- `d_sat`  out  1: current element was clamped.
- `busy`  out  1: a capture is being drained.
- `done`  out  1: one-cycle pulse after the last element is accepted.
- `overrun`  out  1: sticky; a capture edge arrived while draining and was dropped.

## Operation
- Edge detect:
  - `mxu_out_valid` is registered as `prev`.
  - `cap = mxu_out_valid & ~prev`.
  - `prev` resets to 1'b0.
- FSM state IDLE:
  - On `cap`, latch all of `mxu_out` into the internal buffer, clear the indices to 0, and go to SEND.
  - `busy` and `d_valid` are 0.
- FSM state SEND:
  - `busy` = 1 and `d_valid` = 1.
  - A handshake is `d_valid & d_ready`.
  - On a handshake with `d_col != DIM-1`, increment `d_col`.
  - On a handshake with `d_col == DIM-1`, set `d_col` to 0 and increment `d_row`.
  - On a handshake at (DIM-1, DIM-1), go to IDLE and assert `done` the next cycle.
- Back-to-back: if `cap` coincides with the final handshake, the new matrix is latched and the block stays in SEND with indices at 0. `done` still pulses.
- `cap` in SEND in any other cycle is dropped. `overrun` is set to 1 and holds until reset. The buffer is not modified.
- Requantization: values are unsigned; see Configuration.
- `d_data`, `d_row`, `d_col`, `d_last` and `d_sat` are combinational from the buffer and the indices. They hold stable while `d_valid & ~d_ready`.

## Timing
- Reset values:
  - State IDLE.
  - Buffer, indices, `prev`, `done` and `overrun` at 0.
  - Therefore `d_valid`=0, `busy`=0, `d_data`=0, `d_last`=0, `d_sat`=0.
- `cap` sampled high at edge N means `d_valid` is high from after edge N. The first element is acceptable at edge N+1.
- With `d_ready` held high, element k is accepted at edge N+1+k. The last element is accepted at N+DIM².
- `done` is high for the one cycle after the last acceptance.
- `d_ready` deasserted stalls the stream indefinitely, with no data loss.
- `d_ready` high while `d_valid` is low has no effect.
- Asserting `reset_n` low mid-drain returns the block to reset values immediately. The partial stream is abandoned.

## Configuration
- Macro `MXU_DRAIN_SAT_EN`.
- When defined:
  - `d_data = (x > 2^DATA_OUT_WIDTH-1) ? 2^DATA_OUT_WIDTH-1 : x[DATA_OUT_WIDTH-1:0]`.
  - `d_sat` = 1 when a clamp occurred.
- When undefined:
  - `d_data = x[DATA_OUT_WIDTH-1:0]` (truncation).
  - `d_sat` is tied to 0.
- When `DATA_OUT_WIDTH == OUT_BIT_WIDTH`, the value passes through unchanged either way.

## Structure
- Shared package `mxu_pkg` holds:
  - The FSM state enum (IDLE, SEND).
  - Typedefs for the result element and the result matrix.
- One combinational sub-module, `mxu_requant`. It takes one `OUT_BIT_WIDTH` value and produces `d_data` and `d_sat`, and contains the `MXU_DRAIN_SAT_EN` conditional.
- Row/column indices use the existing `Counter` module: the column counter is enabled on handshake, and the row counter on handshake at the last column.

## Test plan
All scenarios use DIM=4, OUT_BIT_WIDTH=8, DATA_OUT_WIDTH=6.
- Basic drain: matrix[r][c] = 4r+c, rising edge, `d_ready`=1 → 16 elements 0..15 on consecutive cycles. `d_last` is high only on (3,3). `done` pulses once. `busy` then falls.
- Backpressure: the same matrix with `d_ready` toggling 1,0,0,1,… → the same 16-value sequence with no duplicates or drops. Data is held stable during stalls.
- Saturation: element value 200.
  - With `MXU_DRAIN_SAT_EN`, `d_data`=63 and `d_sat`=1.
  - Without it, `d_data`=8 and `d_sat`=0.
  - For value 40, both builds give 40.
- Overrun: drop `mxu_out_valid`, then raise it again during element 5 → stream unchanged and `overrun`=1 until reset. Raising it coincident with the final handshake → a new 16-element stream starts with no gap, `done` pulses, and `overrun` stays 0.
- Reset mid-drain: `reset_n` low after element 7 → `d_valid`, `busy`, `d_row` and `d_col` all go to 0 immediately. After release, a level-high `mxu_out_valid` that was already high is captured once (`prev` was reset to 0).
